uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-word handshake of the UART receiver
interface uart_rx_if;
    logic        rx;
    logic [15:0] data;
    logic        data_valid;
    logic        frame_error;
    logic        busy;
    modport master (output rx, input data, data_valid, frame_error, busy);
    modport slave (input rx, output data, data_valid, frame_error, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver that assembles two bytes into one 16-bit word
module uart_rx #(
    parameter int OVS      = 16,
    parameter int GAP_BITS = 4
) (
    input logic clk,
    input logic rst,
    uart_rx_if.slave u
);
    localparam int TW = $clog2(OVS);
    localparam int GW = $clog2(GAP_BITS * OVS);
    localparam logic [TW-1:0] HALF  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL  = TW'(OVS - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_BITS * OVS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
    state_t state, state_n;
    logic rx_m, rx_s;
    logic [1:0] warm;
    logic armed;
    logic [TW-1:0] tick, tick_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic byte_idx, byte_idx_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [7:0] shift, shift_n, byte0, byte0_n;
    logic [15:0] data_n;
    logic dv_n, fe_n;
    assign u.busy = state != IDLE;
    always_comb begin
        state_n    = state;
        tick_n     = tick;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        gap_cnt_n  = gap_cnt;
        shift_n    = shift;
        byte0_n    = byte0;
        data_n     = u.data;
        dv_n       = 1'b0;
        fe_n       = 1'b0;
        case (state)
            IDLE: if (armed && !rx_s) begin
                state_n    = START;
                tick_n     = '0;
                byte_idx_n = 1'b0;
            end
            START: begin
                tick_n = tick + 1'b1;
                if (tick == HALF) begin
                    tick_n    = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? (byte_idx ? GAP : IDLE) : DATA;
                end
            end
            DATA: begin
                tick_n = tick + 1'b1;
                if (tick == FULL) begin
                    tick_n    = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = (bit_idx == 3'd7) ? 3'd0 : bit_idx + 1'b1;
                    state_n   = (bit_idx == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                tick_n = tick + 1'b1;
                if (tick == FULL) begin
                    tick_n = '0;
                    if (!rx_s) begin
                        fe_n       = 1'b1;
                        byte_idx_n = 1'b0;
                        state_n    = IDLE;
                    end else if (!byte_idx) begin
                        byte0_n    = shift;
                        byte_idx_n = 1'b1;
                        gap_cnt_n  = '0;
                        state_n    = GAP;
                    end else begin
                        data_n     = {shift, byte0};
                        dv_n       = 1'b1;
                        byte_idx_n = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            GAP: if (!rx_s) begin
                state_n = START;
                tick_n  = '0;
            end else if (gap_cnt == GLAST) begin
                fe_n       = 1'b1;
                byte_idx_n = 1'b0;
                gap_cnt_n  = '0;
                state_n    = IDLE;
            end else begin
                gap_cnt_n = gap_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // armed blocks a start until the line has been seen high after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            warm          <= '0;
            armed         <= 1'b0;
            state         <= IDLE;
            tick          <= '0;
            bit_idx       <= '0;
            byte_idx      <= 1'b0;
            gap_cnt       <= '0;
            shift         <= '0;
            byte0         <= '0;
            u.data        <= '0;
            u.data_valid  <= 1'b0;
            u.frame_error <= 1'b0;
        end else begin
            rx_m          <= u.rx;
            rx_s          <= rx_m;
            warm          <= {warm[0], 1'b1};
            armed         <= armed | (warm[1] & rx_s);
            state         <= state_n;
            tick          <= tick_n;
            bit_idx       <= bit_idx_n;
            byte_idx      <= byte_idx_n;
            gap_cnt       <= gap_cnt_n;
            shift         <= shift_n;
            byte0         <= byte0_n;
            u.data        <= data_n;
            u.data_valid  <= dv_n;
            u.frame_error <= fe_n;
        end
    end
endmodule
